cpu_wb_scheduler: RTL and testbench

Schedules the single register-file write port between the in-order pipeline writeback (stage 4) and two long-latency producers: the multiply/divide unit (MDU) and the load-return path (LSU). Keeps a 32-entry scoreboard of destination registers with results outstanding, and raises a decode-stage (stage 2) stall on any RAW/WAW hazard against them. Sits between the stage-4 writeback, the long-latency units and `cpu_regfile`, and drives the regfile's `p4_*` write inputs.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/cpu_scoreboard.sv | 45 ++++
 rtl/cpu_wb_scheduler.sv | 133 +++++++++++++
 tb/tb_cpu_wb_scheduler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the CPU writeback scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef struct packed {
        logic        valid;
        logic [4:0]  dst;
        logic [31:0] data;
    } wb_req_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        WB_MDU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/cpu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : cpu_scoreboard
// Description : Pending-destination bitmap with set/clear and 3-port lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_scoreboard
    import cpu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_set_en,
    input  logic [4:0] i_set_reg,
    input  logic       i_clr_en,
    input  logic [4:0] i_clr_reg,
    input  logic [4:0] i_rd_a,
    input  logic [4:0] i_rd_b,
    input  logic [4:0] i_rd_d,
    output logic       o_hazard
);

    logic [31:0] r_pending;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic [31:0] w_next;

    // Set is applied after clear so a same-cycle retire/reissue stays pending.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en && (i_set_reg != REG_ZERO)) w_set_mask[i_set_reg] = 1'b1;
        if (i_clr_en) w_clr_mask[i_clr_reg] = 1'b1;
        w_next    = (r_pending & ~w_clr_mask) | w_set_mask;
        w_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) r_pending <= '0;
        else       r_pending <= w_next;
    end

    assign o_hazard = r_pending[i_rd_a] | r_pending[i_rd_b] | r_pending[i_rd_d];

endmodule
`default_nettype wire

// File: rtl/cpu_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cpu_wb_scheduler
// Description : Register-file write-port arbiter (pipeline > RR{MDU,LSU})
//               with scoreboard-driven decode stall and starvation hold.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_wb_scheduler
    import cpu_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p4_wb_en,
    input  logic [4:0]  p4_wb_reg,
    input  logic [31:0] p4_wb_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_reg,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_reg,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    input  logic        p2_issue_ll,
    input  logic [4:0]  p2_reg_a,
    input  logic [4:0]  p2_reg_b,
    input  logic [4:0]  p2_reg_d,
    output logic        p2_stall,
    output logic        wb_hold,
    output logic        p4_write_en,
    output logic [4:0]  p4_reg_d,
    output logic [31:0] p4_reg_data_d
);

    localparam int              c_CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(STARVE_LIMIT);

    wb_req_t          w_mdu_req;
    wb_req_t          w_lsu_req;
    wb_req_t          w_sel_req;
    logic             w_pipe_own;
    logic             w_mdu_grant;
    logic             w_lsu_grant;
    logic             w_any_grant;
    logic             w_hazard;
    logic             w_issue;
    wb_src_e          r_rr;
    logic [c_CW-1:0]  r_mdu_wait;
    logic [c_CW-1:0]  r_lsu_wait;

    assign w_mdu_req  = '{valid: mdu_valid, dst: mdu_reg, data: mdu_data};
    assign w_lsu_req  = '{valid: lsu_valid, dst: lsu_reg, data: lsu_data};
    assign w_pipe_own = p4_wb_en && (p4_wb_reg != REG_ZERO);

    always_comb begin
        w_mdu_grant = 1'b0;
        w_lsu_grant = 1'b0;
        if (!reset && !w_pipe_own) begin
            if (mdu_valid && lsu_valid) begin
                if (r_rr == WB_MDU) w_mdu_grant = 1'b1;
                else                w_lsu_grant = 1'b1;
            end else if (mdu_valid) begin
                w_mdu_grant = 1'b1;
            end else if (lsu_valid) begin
                w_lsu_grant = 1'b1;
            end
        end
    end

    assign w_any_grant = w_mdu_grant | w_lsu_grant;
    assign w_sel_req   = w_mdu_grant ? w_mdu_req : w_lsu_req;
    assign mdu_ready   = w_mdu_grant;
    assign lsu_ready   = w_lsu_grant;

    // A granted write to r0 is consumed but never reaches the regfile.
    always_comb begin
        p4_write_en   = 1'b0;
        p4_reg_d      = '0;
        p4_reg_data_d = '0;
        if (!reset) begin
            if (w_pipe_own) begin
                p4_write_en   = 1'b1;
                p4_reg_d      = p4_wb_reg;
                p4_reg_data_d = p4_wb_data;
            end else if (w_any_grant && w_sel_req.valid) begin
                p4_write_en   = (w_sel_req.dst != REG_ZERO);
                p4_reg_d      = w_sel_req.dst;
                p4_reg_data_d = w_sel_req.data;
            end
        end
    end

    assign p2_stall = reset | w_hazard;
    assign w_issue  = p2_issue_ll && !p2_stall;

    cpu_scoreboard u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .i_set_en  (w_issue),
        .i_set_reg (p2_reg_d),
        .i_clr_en  (w_any_grant),
        .i_clr_reg (w_sel_req.dst),
        .i_rd_a    (p2_reg_a),
        .i_rd_b    (p2_reg_b),
        .i_rd_d    (p2_reg_d),
        .o_hazard  (w_hazard)
    );

    function automatic logic [c_CW-1:0] next_wait(input logic valid, input logic ready,
                                                  input logic [c_CW-1:0] cnt);
        if (!valid || ready) return '0;
        if (cnt == c_LIMIT)  return cnt;
        return cnt + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr       <= WB_MDU;
            r_mdu_wait <= '0;
            r_lsu_wait <= '0;
        end else begin
            r_mdu_wait <= next_wait(mdu_valid, w_mdu_grant, r_mdu_wait);
            r_lsu_wait <= next_wait(lsu_valid, w_lsu_grant, r_lsu_wait);
            if (w_any_grant) r_rr <= w_mdu_grant ? WB_LSU : WB_MDU;
        end
    end

    assign wb_hold = !reset && ((r_mdu_wait == c_LIMIT) || (r_lsu_wait == c_LIMIT));

endmodule
`default_nettype wire

// File: tb/tb_cpu_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_wb_scheduler
// Description : Randomized bench for cpu_wb_scheduler against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_wb_scheduler;

    localparam int c_LIMIT  = 8;
    localparam int c_CYCLES = 4000;

    logic        clock = 1'b0;
    logic        reset;
    logic        p4_wb_en;
    logic [4:0]  p4_wb_reg;
    logic [31:0] p4_wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_reg;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_reg;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        p2_issue_ll;
    logic [4:0]  p2_reg_a;
    logic [4:0]  p2_reg_b;
    logic [4:0]  p2_reg_d;
    logic        p2_stall;
    logic        wb_hold;
    logic        p4_write_en;
    logic [4:0]  p4_reg_d;
    logic [31:0] p4_reg_data_d;

    always #5 clock = ~clock;

    cpu_wb_scheduler #(.STARVE_LIMIT(c_LIMIT)) dut (
        .clock         (clock),
        .reset         (reset),
        .p4_wb_en      (p4_wb_en),
        .p4_wb_reg     (p4_wb_reg),
        .p4_wb_data    (p4_wb_data),
        .mdu_valid     (mdu_valid),
        .mdu_reg       (mdu_reg),
        .mdu_data      (mdu_data),
        .mdu_ready     (mdu_ready),
        .lsu_valid     (lsu_valid),
        .lsu_reg       (lsu_reg),
        .lsu_data      (lsu_data),
        .lsu_ready     (lsu_ready),
        .p2_issue_ll   (p2_issue_ll),
        .p2_reg_a      (p2_reg_a),
        .p2_reg_b      (p2_reg_b),
        .p2_reg_d      (p2_reg_d),
        .p2_stall      (p2_stall),
        .wb_hold       (wb_hold),
        .p4_write_en   (p4_write_en),
        .p4_reg_d      (p4_reg_d),
        .p4_reg_data_d (p4_reg_data_d)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference state: set of outstanding registers, per-unit wait, whose turn.
    bit m_pend [32];
    int m_wait_mdu;
    int m_wait_lsu;
    bit m_turn_lsu;

    initial begin
        bit          pipe, e_mr, e_lr, e_stall, e_hold, e_we;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        int          wb_pct;

        reset = 1'b1; p4_wb_en = 1'b0; p4_wb_reg = '0; p4_wb_data = '0;
        mdu_valid = 1'b0; mdu_reg = '0; mdu_data = '0;
        lsu_valid = 1'b0; lsu_reg = '0; lsu_data = '0;
        p2_issue_ll = 1'b0; p2_reg_a = '0; p2_reg_b = '0; p2_reg_d = '0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_wait_mdu = 0; m_wait_lsu = 0; m_turn_lsu = 1'b0;

        @(posedge clock); #1;
        for (int cyc = 0; cyc < c_CYCLES; cyc++) begin
            // Alternate light and heavy pipeline traffic to provoke starvation.
            wb_pct = ((cyc / 400) % 2 == 1) ? 95 : 40;
            reset  = (cyc < 2) || ($urandom_range(0, 249) == 0);
            p4_wb_en   = ($urandom_range(0, 99) < wb_pct);
            p4_wb_reg  = 5'($urandom_range(0, 7));
            p4_wb_data = $urandom;
            if (reset) begin
                mdu_valid = 1'b0;
                lsu_valid = 1'b0;
            end else begin
                if (!mdu_valid) begin
                    mdu_valid = ($urandom_range(0, 2) == 0);
                    mdu_reg   = 5'($urandom_range(0, 7));
                    mdu_data  = $urandom;
                end
                if (!lsu_valid) begin
                    lsu_valid = ($urandom_range(0, 2) == 0);
                    lsu_reg   = 5'($urandom_range(0, 7));
                    lsu_data  = $urandom;
                end
            end
            p2_issue_ll = $urandom_range(0, 1);
            p2_reg_a    = 5'($urandom_range(0, 7));
            p2_reg_b    = 5'($urandom_range(0, 7));
            p2_reg_d    = 5'($urandom_range(0, 7));
            #2;

            pipe = p4_wb_en && (p4_wb_reg != 0);
            e_mr = 1'b0;
            e_lr = 1'b0;
            if (!reset && !pipe) begin
                if (mdu_valid && lsu_valid) begin
                    e_lr = m_turn_lsu;
                    e_mr = !m_turn_lsu;
                end else begin
                    e_mr = mdu_valid;
                    e_lr = lsu_valid;
                end
            end
            e_stall = reset || m_pend[p2_reg_a] || m_pend[p2_reg_b] || m_pend[p2_reg_d];
            e_hold  = !reset && (m_wait_mdu == c_LIMIT || m_wait_lsu == c_LIMIT);
            e_we = 1'b0; e_reg = '0; e_data = '0;
            if (!reset) begin
                if (pipe) begin
                    e_we = 1'b1; e_reg = p4_wb_reg; e_data = p4_wb_data;
                end else if (e_mr) begin
                    e_we = (mdu_reg != 0); e_reg = mdu_reg; e_data = mdu_data;
                end else if (e_lr) begin
                    e_we = (lsu_reg != 0); e_reg = lsu_reg; e_data = lsu_data;
                end
            end

            chk("mdu_ready", mdu_ready, e_mr);
            chk("lsu_ready", lsu_ready, e_lr);
            chk("p2_stall", p2_stall, e_stall);
            chk("wb_hold", wb_hold, e_hold);
            chk("p4_write_en", p4_write_en, e_we);
            if (e_we || reset) begin
                chk("p4_reg_d", p4_reg_d, e_reg);
                chk("p4_reg_data_d", p4_reg_data_d, e_data);
            end

            if (reset) begin
                foreach (m_pend[i]) m_pend[i] = 1'b0;
                m_wait_mdu = 0; m_wait_lsu = 0; m_turn_lsu = 1'b0;
            end else begin
                m_wait_mdu = (mdu_valid && !e_mr) ? ((m_wait_mdu < c_LIMIT) ? m_wait_mdu + 1 : c_LIMIT) : 0;
                m_wait_lsu = (lsu_valid && !e_lr) ? ((m_wait_lsu < c_LIMIT) ? m_wait_lsu + 1 : c_LIMIT) : 0;
                if (e_mr) m_pend[mdu_reg] = 1'b0;
                if (e_lr) m_pend[lsu_reg] = 1'b0;
                if (p2_issue_ll && !e_stall && p2_reg_d != 0) m_pend[p2_reg_d] = 1'b1;
                if (e_mr)      m_turn_lsu = 1'b1;
                else if (e_lr) m_turn_lsu = 1'b0;
            end

            @(posedge clock); #1;
            if (e_mr) mdu_valid = 1'b0;
            if (e_lr) lsu_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
